mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported memory bus (cbus) between the core's instruction-fetch port (ibus) and data port (dbus).
- Sits between the core outputs ireq/dreq and the memory/cache interface.
- Non-preemptive and single-outstanding. Data requests take priority; a starvation counter bounds how long fetch can be locked out.

Parameters:
- STARVE_MAX, 4: consecutive dbus grants while ibus is waiting before ibus is forced to win the next arbitration. Range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ireq_valid  in  1  fetch request; held by core until iresp_data_ok
- ireq_addr  in  64  fetch address, 4-byte aligned
- iresp_addr_ok  out  1  fetch request accepted (grant pulse)
- iresp_data_ok  out  1  fetch data valid (1-cycle pulse)
- iresp_data  out  32  fetched instruction
- dreq_valid  in  1  data request; held until dresp_data_ok
- dreq_addr  in  64  data address
- dreq_size  in  3  msize_t encoding
- dreq_strobe  in  8  byte write enables; 0 means read
- dreq_data  in  64  write data
- dresp_addr_ok  out  1  data request accepted
- dresp_data_ok  out  1  data response valid (1-cycle pulse)
- dresp_data  out  64  read data
- creq_valid  out  1  downstream request
- creq_is_write  out  1  1 when latched strobe is nonzero
- creq_addr  out  64  downstream address
- creq_size  out  3  downstream size
- creq_strobe  out  8  downstream strobe
- creq_data  out  64  downstream write data
- cresp_ready  in  1  downstream transaction complete (1-cycle pulse)
- cresp_data  in  64  downstream read data, valid with cresp_ready

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. The state register and a latched request register (addr, size, strobe, data) are the only stored request context.
- Reset (async): state=IDLE, starve_cnt=0, latched request cleared.
  - While reset is high, all outputs are 0, including creq_*, addr_ok and data_ok.
  - A transaction in flight at reset is abandoned. Any cresp_ready that arrives afterwards in IDLE is ignored.
- IDLE, cycle T, arbitration:
  - force_i = (starve_cnt == STARVE_MAX) && ireq_valid.
  - If force_i, or (ireq_valid && !dreq_valid): grant I. Latch ireq_addr, size=MSIZE4, strobe=0. Pulse iresp_addr_ok in T. Next state BUSY_I. starve_cnt reset to 0.
  - Else if dreq_valid: grant D. Latch all dreq fields. Pulse dresp_addr_ok in T. Next state BUSY_D. starve_cnt increments (saturating at STARVE_MAX) if ireq_valid, else resets to 0.
  - Else: stay in IDLE.
- addr_ok is combinational from IDLE and the request inputs. It is never asserted outside IDLE.
- BUSY_x:
  - creq_valid=1 and creq_* are driven from the latched register. They are stable for the whole transaction, starting at T+1.
  - On cresp_ready: the owner's data_ok is asserted in the same cycle (combinational pass-through).
  - Next state is IDLE, giving a mandatory one-cycle bubble before the next grant.
  - Minimum fetch latency, request to data_ok: 2 cycles when cresp_ready arrives in the first BUSY cycle.
- iresp_data = latched addr[2] ? cresp_data[63:32] : cresp_data[31:0].
- dresp_data = cresp_data, passed unmodified; a write returns don't-care data but still pulses data_ok.
- Non-owner outputs: data_ok is 0 and data is 0.
- Requester dropping valid mid-transaction: protocol violation. The arbiter still completes from its latched copy and pulses data_ok.
- Simultaneous ireq_valid and dreq_valid in IDLE with starve_cnt < STARVE_MAX: D wins.
- cresp_ready in IDLE: ignored. No data_ok.
- starve_cnt is 4 bits and never exceeds STARVE_MAX.

Decomposition:
- Add to the shared pipes package:
  - typedef arb_state_t enum {IDLE, BUSY_I, BUSY_D}
  - struct cbus_req_t {valid, is_write, addr, size, strobe, data}
  - struct cbus_resp_t {ready, data}
- msize_t and MSIZE4 are reused from common.
- No sub-module is natural; the state machine, latch and counter stay in one module.
- The core instantiates mem_arbiter in place of its direct ireq/dreq connections.

Test Plan:
- Fetch only: ireq_valid=1, addr=0x8000_0004; cresp_ready one cycle after creq_valid with cresp_data=0x0000_0013_DEAD_BEEF -> iresp_addr_ok at T, creq_valid at T+1 with size=MSIZE4 and strobe=0, iresp_data_ok with iresp_data=0x0000_0013.
- Contention: ireq_valid and dreq_valid both 1 in IDLE, dreq addr=0x8000_1000 strobe=0xFF data=0x1234 -> D granted first, creq_is_write=1 and creq_data=0x1234; after dresp_data_ok plus one bubble cycle, I is granted.
- Starvation, STARVE_MAX=4: ireq held continuously, dreq re-asserted after every completion -> exactly 4 D grants, then an I grant, and starve_cnt returns to 0.
- Slow memory: cresp_ready delayed 10 cycles -> creq_* stable for all 10 cycles, a single data_ok pulse, no second grant during BUSY.
- Reset mid-transaction: assert reset in BUSY_D, then pulse cresp_ready after release -> creq_valid=0 immediately (asynchronously), state IDLE, no data_ok.
- Stray response: cresp_ready=1 in IDLE with no requests -> both data_ok outputs stay 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory bus arbiter: access sizes, arbiter state
// encoding and the downstream (cbus) request/response bundles.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic [63:0] data;
    } cbus_resp_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Non-preemptive, single-outstanding arbiter sharing one memory bus between
// instruction fetch (ibus) and data (dbus); dbus has priority, bounded by a starvation counter.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ireq_valid,
    input  logic [63:0]         ireq_addr,
    output logic                iresp_addr_ok,
    output logic                iresp_data_ok,
    output logic [31:0]         iresp_data,

    input  logic                dreq_valid,
    input  logic [63:0]         dreq_addr,
    input  logic [2:0]          dreq_size,
    input  logic [7:0]          dreq_strobe,
    input  logic [63:0]         dreq_data,
    output logic                dresp_addr_ok,
    output logic                dresp_data_ok,
    output logic [63:0]         dresp_data,

    output logic                creq_valid,
    output logic                creq_is_write,
    output logic [63:0]         creq_addr,
    output logic [2:0]          creq_size,
    output logic [7:0]          creq_strobe,
    output logic [63:0]         creq_data,
    input  logic                cresp_ready,
    input  logic [63:0]         cresp_data,

    output arb_state_t          dbg_state,
    output logic [STARVE_W-1:0] dbg_starve_cnt
);

    // Handshake: a requester holds *_valid until its data_ok pulse. addr_ok
    // is a combinational grant pulse only in IDLE; creq_valid stays high
    // from the cycle after the grant until cresp_ready, which ends the
    // transaction and is passed straight through as the owner's data_ok.

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt;
    logic [63:0]         addr_q;
    msize_t              size_q;
    logic [7:0]          strobe_q;
    logic [63:0]         data_q;

    logic       force_i;
    logic       grant_i;
    logic       grant_d;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    assign cresp   = '{ready: cresp_ready, data: cresp_data};
    assign force_i = (starve_cnt == STARVE_LIMIT) && ireq_valid;
    assign grant_i = (state_q == IDLE) && (force_i || (ireq_valid && !dreq_valid));
    assign grant_d = (state_q == IDLE) && !grant_i && dreq_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = BUSY_I;
                end else if (grant_d) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (cresp.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch and starvation counter only move on a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            size_q     <= MSIZE1;
            strobe_q   <= '0;
            data_q     <= '0;
            starve_cnt <= '0;
        end else if (grant_i) begin
            addr_q     <= ireq_addr;
            size_q     <= MSIZE4;
            strobe_q   <= '0;
            data_q     <= '0;
            starve_cnt <= '0;
        end else if (grant_d) begin
            addr_q   <= dreq_addr;
            size_q   <= msize_t'(dreq_size);
            strobe_q <= dreq_strobe;
            data_q   <= dreq_data;
            if (ireq_valid) begin
                starve_cnt <= (starve_cnt == STARVE_LIMIT) ? starve_cnt
                                                           : starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    always_comb begin
        creq          = '0;
        iresp_addr_ok = grant_i && !reset;
        dresp_addr_ok = grant_d && !reset;
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        if (state_q != IDLE) begin
            creq.valid    = 1'b1;
            creq.is_write = |strobe_q;
            creq.addr     = addr_q;
            creq.size     = size_q;
            creq.strobe   = strobe_q;
            creq.data     = data_q;
        end
        if (state_q == BUSY_I && cresp.ready) begin
            iresp_data_ok = 1'b1;
            iresp_data    = addr_q[2] ? cresp.data[63:32] : cresp.data[31:0];
        end
        if (state_q == BUSY_D && cresp.ready) begin
            dresp_data_ok = 1'b1;
            dresp_data    = cresp.data;
        end
    end

    assign creq_valid     = creq.valid;
    assign creq_is_write  = creq.is_write;
    assign creq_addr      = creq.addr;
    assign creq_size      = creq.size;
    assign creq_strobe    = creq.strobe;
    assign creq_data      = creq.data;
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, starvation, slow memory,
// reset during a transaction and stray responses.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok, iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        creq_valid, creq_is_write;
    logic [63:0] creq_addr;
    logic [2:0]  creq_size;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ready;
    logic [63:0] cresp_data;
    arb_state_t  dbg_state;
    logic [3:0]  dbg_starve_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_addr(creq_addr),
        .creq_size(creq_size), .creq_strobe(creq_strobe), .creq_data(creq_data),
        .cresp_ready(cresp_ready), .cresp_data(cresp_data),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ireq_valid = 1'b1; dreq_valid = 1'b1;
        ireq_addr = 64'h8000_0000; dreq_addr = 64'h8000_1000;
        dreq_size = 3'd3; dreq_strobe = 8'hFF; dreq_data = 64'h1;
        cresp_ready = 1'b1; cresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #3;
        n_checks++; if ({iresp_addr_ok, dresp_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_addr_ok: got %b want 00", {iresp_addr_ok, dresp_addr_ok}); end
        n_checks++; if ({iresp_data_ok, dresp_data_ok, creq_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_ok_valid: got %b want 000", {iresp_data_ok, dresp_data_ok, creq_valid}); end
        n_checks++; if (creq_addr !== 64'h0 || creq_strobe !== 8'h0) begin n_fail++; $display("FAIL reset_creq: got addr %h strobe %h want 0", creq_addr, creq_strobe); end
        n_checks++; if (dbg_state !== IDLE || dbg_starve_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d/%0d want IDLE/0", dbg_state, dbg_starve_cnt); end
        step(); step();
        ireq_valid = 1'b0; dreq_valid = 1'b0; cresp_ready = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_fetch(input logic [63:0] addr, input logic [63:0] cdata,
                              input logic [31:0] exp);
        ireq_valid = 1'b1; ireq_addr = addr;
        @(negedge clk);
        n_checks++; if (iresp_addr_ok !== 1'b1 || dresp_addr_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_grant: got i=%b d=%b want i=1 d=0", iresp_addr_ok, dresp_addr_ok); end
        step();
        n_checks++; if (creq_valid !== 1'b1 || creq_addr !== addr) begin n_fail++; $display("FAIL fetch_creq: got valid=%b addr=%h want 1 %h", creq_valid, creq_addr, addr); end
        n_checks++; if (creq_size !== 3'd2 || creq_strobe !== 8'h0 || creq_is_write !== 1'b0) begin n_fail++; $display("FAIL fetch_size: got size=%0d strobe=%h wr=%b want 2 00 0", creq_size, creq_strobe, creq_is_write); end
        n_checks++; if (iresp_addr_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_grant: got %b want 0", iresp_addr_ok); end
        cresp_ready = 1'b1; cresp_data = cdata;
        @(negedge clk);
        n_checks++; if (iresp_data_ok !== 1'b1 || iresp_data !== exp) begin n_fail++; $display("FAIL fetch_data: got ok=%b data=%h want 1 %h", iresp_data_ok, iresp_data, exp); end
        n_checks++; if (dresp_data_ok !== 1'b0 || dresp_data !== 64'h0) begin n_fail++; $display("FAIL fetch_nonowner: got ok=%b data=%h want 0 0", dresp_data_ok, dresp_data); end
        step();
        ireq_valid = 1'b0; cresp_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (dbg_state !== IDLE || iresp_data_ok !== 1'b0) begin n_fail++; $display("FAIL fetch_done: got state=%0d ok=%b want IDLE 0", dbg_state, iresp_data_ok); end
        step();
    endtask

    task automatic test_contention();
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0008;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_1000; dreq_size = 3'd3;
        dreq_strobe = 8'hFF; dreq_data = 64'h1234;
        @(negedge clk);
        n_checks++; if (dresp_addr_ok !== 1'b1 || iresp_addr_ok !== 1'b0) begin n_fail++; $display("FAIL cont_grant_d: got d=%b i=%b want d=1 i=0", dresp_addr_ok, iresp_addr_ok); end
        step();
        n_checks++; if (creq_is_write !== 1'b1 || creq_data !== 64'h1234 || creq_addr !== 64'h8000_1000) begin n_fail++; $display("FAIL cont_creq: got wr=%b data=%h addr=%h want 1 1234 80001000", creq_is_write, creq_data, creq_addr); end
        n_checks++; if (creq_strobe !== 8'hFF || creq_size !== 3'd3 || dbg_starve_cnt !== 4'd1) begin n_fail++; $display("FAIL cont_fields: got strobe=%h size=%0d starve=%0d want ff 3 1", creq_strobe, creq_size, dbg_starve_cnt); end
        cresp_ready = 1'b1; cresp_data = 64'hA5A5_0000_0000_5A5A;
        @(negedge clk);
        n_checks++; if (dresp_data_ok !== 1'b1 || dresp_data !== 64'hA5A5_0000_0000_5A5A || iresp_data_ok !== 1'b0) begin n_fail++; $display("FAIL cont_d_done: got ok=%b data=%h iok=%b want 1 a5a500000000 5a5a 0", dresp_data_ok, dresp_data, iresp_data_ok); end
        step();
        dreq_valid = 1'b0; cresp_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (dbg_state !== IDLE || iresp_addr_ok !== 1'b1) begin n_fail++; $display("FAIL cont_grant_i: got state=%0d iok=%b want IDLE 1", dbg_state, iresp_addr_ok); end
        step();
        n_checks++; if (dbg_state !== BUSY_I || dbg_starve_cnt !== 4'd0) begin n_fail++; $display("FAIL cont_busy_i: got state=%0d starve=%0d want BUSY_I 0", dbg_state, dbg_starve_cnt); end
        cresp_ready = 1'b1; cresp_data = 64'h0000_0000_0000_0073;
        @(negedge clk);
        n_checks++; if (iresp_data_ok !== 1'b1 || iresp_data !== 32'h73) begin n_fail++; $display("FAIL cont_i_done: got ok=%b data=%h want 1 00000073", iresp_data_ok, iresp_data); end
        step();
        ireq_valid = 1'b0; cresp_ready = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        int d_grants = 0;
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0100;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_3000; dreq_size = 3'd3;
        dreq_strobe = 8'h00; dreq_data = 64'h0;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            n_checks++; if (dbg_starve_cnt !== 4'(r)) begin n_fail++; $display("FAIL starve_cnt_%0d: got %0d want %0d", r, dbg_starve_cnt, r); end
            if (dresp_addr_ok === 1'b1) d_grants++;
            if (r < 4) begin
                n_checks++; if (dresp_addr_ok !== 1'b1 || iresp_addr_ok !== 1'b0) begin n_fail++; $display("FAIL starve_d_%0d: got d=%b i=%b want d=1 i=0", r, dresp_addr_ok, iresp_addr_ok); end
            end else begin
                n_checks++; if (iresp_addr_ok !== 1'b1 || dresp_addr_ok !== 1'b0) begin n_fail++; $display("FAIL starve_force_i: got i=%b d=%b want i=1 d=0", iresp_addr_ok, dresp_addr_ok); end
            end
            step();
            cresp_ready = 1'b1; cresp_data = 64'h0;
            step();
            cresp_ready = 1'b0;
        end
        ireq_valid = 1'b0; dreq_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (d_grants != 4) begin n_fail++; $display("FAIL starve_d_count: got %0d want 4", d_grants); end
        n_checks++; if (dbg_starve_cnt !== 4'd0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL starve_end: got starve=%0d state=%0d want 0 IDLE", dbg_starve_cnt, dbg_state); end
        step();
    endtask

    task automatic test_slow_memory();
        int grants = 0;
        int dones  = 0;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_2008; dreq_size = 3'd3;
        dreq_strobe = 8'h00; dreq_data = 64'h0;
        @(negedge clk);
        n_checks++; if (dresp_addr_ok !== 1'b1) begin n_fail++; $display("FAIL slow_grant: got %b want 1", dresp_addr_ok); end
        step();
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                // requester misbehaves: drops valid, changes address, fetch arrives
                dreq_valid = 1'b0; dreq_addr = 64'hDEAD_DEAD_DEAD_DEAD;
                ireq_valid = 1'b1; ireq_addr = 64'h8000_0200;
            end
            @(negedge clk);
            if (creq_valid !== 1'b1 || creq_addr !== 64'h8000_2008 || creq_size !== 3'd3) grants += 100;
            if (iresp_addr_ok !== 1'b0 || dresp_addr_ok !== 1'b0) grants++;
            if (iresp_data_ok !== 1'b0 || dresp_data_ok !== 1'b0) dones++;
            step();
        end
        n_checks++; if (grants != 0) begin n_fail++; $display("FAIL slow_stable: got %0d bad cycles code want 0", grants); end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL slow_early_ok: got %0d early data_ok want 0", dones); end
        cresp_ready = 1'b1; cresp_data = 64'hCAFE_F00D_1234_5678;
        @(negedge clk);
        n_checks++; if (dresp_data_ok !== 1'b1 || dresp_data !== 64'hCAFE_F00D_1234_5678) begin n_fail++; $display("FAIL slow_data: got ok=%b data=%h want 1 cafef00d12345678", dresp_data_ok, dresp_data); end
        step();
        ireq_valid = 1'b0; cresp_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (dresp_data_ok !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL slow_single_pulse: got ok=%b state=%0d want 0 IDLE", dresp_data_ok, dbg_state); end
        step();
    endtask

    task automatic test_reset_mid();
        dreq_valid = 1'b1; dreq_addr = 64'h8000_4000; dreq_size = 3'd2;
        dreq_strobe = 8'h0F; dreq_data = 64'h55;
        step();
        n_checks++; if (creq_valid !== 1'b1 || dbg_state !== BUSY_D) begin n_fail++; $display("FAIL rmid_busy: got valid=%b state=%0d want 1 BUSY_D", creq_valid, dbg_state); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (creq_valid !== 1'b0 || dbg_state !== IDLE || creq_addr !== 64'h0) begin n_fail++; $display("FAIL rmid_async: got valid=%b state=%0d addr=%h want 0 IDLE 0", creq_valid, dbg_state, creq_addr); end
        n_checks++; if (dresp_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rmid_addr_ok: got %b want 0", dresp_addr_ok); end
        dreq_valid = 1'b0;
        step();
        reset = 1'b0;
        cresp_ready = 1'b1; cresp_data = 64'h1111_2222_3333_4444;
        @(negedge clk);
        n_checks++; if ({dresp_data_ok, iresp_data_ok, creq_valid} !== 3'b000) begin n_fail++; $display("FAIL rmid_late_resp: got %b want 000", {dresp_data_ok, iresp_data_ok, creq_valid}); end
        step();
        cresp_ready = 1'b0;
        step();
    endtask

    task automatic test_stray_response();
        cresp_ready = 1'b1; cresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        n_checks++; if (iresp_data_ok !== 1'b0 || dresp_data_ok !== 1'b0) begin n_fail++; $display("FAIL stray_ok: got i=%b d=%b want 0 0", iresp_data_ok, dresp_data_ok); end
        n_checks++; if (iresp_data !== 32'h0 || dresp_data !== 64'h0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL stray_data: got i=%h d=%h state=%0d want 0 0 IDLE", iresp_data, dresp_data, dbg_state); end
        step();
        cresp_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch(64'h8000_0004, 64'h0000_0013_DEAD_BEEF, 32'h0000_0013);
        test_fetch(64'h8000_0000, 64'h0000_0013_DEAD_BEEF, 32'hDEAD_BEEF);
        test_contention();
        test_starvation();
        test_slow_memory();
        test_reset_mid();
        test_stray_response();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
